// File: rtl/hamming_codec_arbiter.sv
// hamming_codec_arbiter: round-robin sharing of one SEC-DED codec between two requesters
// ports: req_valid/req_mode/req_data0/req_data1/req_ready = job intake (one-hot grant),
//        codec_data/codec_mode out, codec_result/codec_syndrome/codec_errors in = shared codec,
//        rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_status = held response channel, busy = not idle
module hamming_codec_arbiter #(
  parameter int CODEC_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_mode,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic [7:0] codec_data,
  output logic       codec_mode,
  input  logic [7:0] codec_result,
  input  logic [3:0] codec_syndrome,
  input  logic [1:0] codec_errors,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic [7:0] rsp_status,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, mode_q, mode_d, id_q, id_d, hs, g;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d, rdat_q, rdat_d, stat_q, stat_d, sel;
  always_comb begin
    // on a tie the requester that did not win last time is granted
    req_ready = (rst || state_q != IDLE) ? 2'b00 :
                (req_valid == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req_valid;
    g = req_ready[1];
    hs = |(req_valid & req_ready);
    sel = g ? req_data1 : req_data0;
    state_d = state_q;
    last_d = last_q;
    mode_d = mode_q;
    id_d = id_q;
    cnt_d = cnt_q;
    data_d = data_q;
    rdat_d = rdat_q;
    stat_d = stat_q;
    case (state_q)
      IDLE: if (hs) begin
        state_d = WAIT;
        mode_d = req_mode[g];
        data_d = req_mode[g] ? sel : {4'h0, sel[3:0]};
        id_d = g;
        last_d = g;
        cnt_d = 3'(CODEC_LAT - 1);
      end
      WAIT: if (cnt_q == 3'd0) begin
        state_d = RESP;
        rdat_d = codec_result;
        stat_d = mode_q ? {2'b00, codec_syndrome, codec_errors} : 8'h00;
      end else cnt_d = cnt_q - 3'd1;
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      mode_q <= 1'b0;
      id_q <= 1'b0;
      cnt_q <= 3'd0;
      data_q <= 8'h00;
      rdat_q <= 8'h00;
      stat_q <= 8'h00;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      mode_q <= mode_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      rdat_q <= rdat_d;
      stat_q <= stat_d;
    end
  end
  assign codec_data = data_q;
  assign codec_mode = mode_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_id = id_q;
  assign rsp_data = rdat_q;
  assign rsp_status = stat_q;
  assign busy = state_q != IDLE;
endmodule

// File: doc/hamming_codec_arbiter.md
# hamming_codec_arbiter

Round-robin scheduler that shares one SEC-DED Hamming codec datapath (combinational encoder plus decoder) between two requesters. It accepts encode or decode jobs over valid/ready handshakes and drives the shared codec inputs. It waits a programmable number of cycles for the codec to settle, then captures the result into a held response channel tagged with the requester id. It sits between the pin-level control logic and the codec instances, so the codec never sees two jobs at once.

## Interface
- `CODEC_LAT`, default 1: cycles between driving the codec inputs and capturing its outputs. Legal range 1..8.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  bit i: requester i has a job.
- `req_mode`  in  2  bit i: 0 = encode, 1 = decode.
- `req_data0`  in  8  requester 0 payload.
- `req_data1`  in  8  requester 1 payload.
- `req_ready`  out  2  one-hot grant; job i is accepted when `req_valid[i] & req_ready[i]`.
- `codec_data`  out  8  latched job data driven to the codec.
- `codec_mode`  out  1  latched job mode.
- `codec_result`  in  8  codec output: codeword on encode, corrected data on decode.
- `codec_syndrome`  in  4  decoder syndrome.
- `codec_errors`  in  2  decoder error flags.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  requester that issued the job.
- `rsp_data`  out  8  captured `codec_result`.
- `rsp_status`  out  8  `{2'b0, syndrome, errors}` on decode; 8'h00 on encode.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: only state where `req_ready` can be nonzero.
  - WAIT: counting down the codec settle time.
  - RESP: `rsp_valid` = 1.
  - Any unencoded state goes to IDLE.
- Arbitration in IDLE is re-evaluated every cycle; no grant is locked before the handshake.
  - Only one `req_valid` bit set: that requester is granted.
  - Both set: the requester other than `last_grant` is granted.
  - Neither set: `req_ready` = 2'b00.
- `req_ready` is combinational from the state, `req_valid` and `last_grant`. It is zero outside IDLE.
- On handshake (IDLE):
  - Latch `codec_mode` from `req_mode[i]`.
  - Latch `codec_data`: `{4'b0, data[3:0]}` if encode, full 8 bits if decode.
  - Latch `rsp_id` = i and set `last_grant` = i.
  - Load the wait counter with `CODEC_LAT-1` and go to WAIT.
- WAIT: the counter decrements each cycle. On the cycle the counter is 0:
  - Capture `rsp_data` ← `codec_result`.
  - Capture `rsp_status` per mode.
  - Go to RESP.
- RESP: `rsp_valid`, `rsp_id`, `rsp_data` and `rsp_status` are held stable until `rsp_ready`. When `rsp_valid & rsp_ready`, go to IDLE.
- `codec_data` and `codec_mode` hold their last job values in all states. They change only on a handshake.
- A requester dropping `req_valid` without a handshake is legal. No job is recorded.
- Reset values:
  - State = IDLE, `last_grant` = 1 (requester 0 wins the first tie).
  - `req_ready` = 0 during reset; `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_status`, `codec_data`, `codec_mode` and `busy` = 0.
- Reset mid-operation (WAIT or RESP): the in-flight job is discarded with no response. The block is in IDLE on the cycle after `rst` deasserts.

## Timing
- Handshake in cycle N:
  - `busy` = 1 and `codec_data` is valid from N+1.
  - Capture occurs at the end of cycle N+`CODEC_LAT`.
  - `rsp_valid` = 1 from cycle N+`CODEC_LAT`+1.
- Response accepted in cycle M: state is IDLE in M+1, and the next grant can handshake in M+1.
- Minimum spacing between handshakes is `CODEC_LAT`+2 cycles. For `CODEC_LAT`=1 this is 3 cycles.
- `codec_result` values present before the capture cycle are ignored. The codec must be stable `CODEC_LAT` cycles after `codec_data` changes.
- `rsp_ready` asserted while `rsp_valid` = 0 has no effect.

## Test plan
The bench codec model is: `result` = `data ^ 8'hFF`, `syndrome` = `data[3:0]`, `errors` = `data[5:4]`.

- **Single encode:** `CODEC_LAT`=1, req0 valid, mode 0, data 8'hA5, handshake at N, `rsp_ready`=1 → `codec_data`=8'h05 at N+1. At N+2: `rsp_valid`=1, `rsp_id`=0, `rsp_data`=8'hFA, `rsp_status`=8'h00.
- **Single decode:** req1, mode 1, data 8'h3C → `codec_data`=8'h3C, `rsp_id`=1, `rsp_data`=8'hC3, `rsp_status`=8'h33.
- **Contention:** both requesters valid continuously from reset → grant order 0,1,0,1,… with no requester granted twice in a row. `req_ready` is never 2'b11.
- **Back-pressure:** `rsp_ready` held low 5 cycles in RESP → `rsp_valid` and all rsp fields stable, `req_ready`=2'b00, `busy`=1. Accept on cycle M → new handshake possible at M+1.
- **Long latency:** `CODEC_LAT`=3, model output glitched to 8'h00 during the first two WAIT cycles → `rsp_valid` at N+4. `rsp_data` equals the value present in the final WAIT cycle.
- **Reset during WAIT:** `rst` high for 1 cycle → no `rsp_valid` ever for that job, `busy`=0 next cycle. A subsequent tie grants requester 0.
